rb_packet_reader: RTL and testbench



---
 rtl/rb_packet_reader.sv | 89 ++++++++
 tb/tb_rb_packet_reader.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/rb_packet_reader.sv
// rb_packet_reader: pops ring-buffer words and re-emits them as a registered packet stream with sop/eop and a delivered-packet count
module rb_packet_reader #(
  parameter int DATA_SIZE = 32,
  parameter int LEN_SIZE  = 16,
  parameter int CNT_SIZE  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 rx_i,
  output logic                 rx_ack_o,
  input  logic [DATA_SIZE-1:0] data_i,
  output logic                 tx_o,
  input  logic                 tx_ack_i,
  output logic [DATA_SIZE-1:0] data_o,
  output logic                 sop_o,
  output logic                 eop_o,
  output logic                 busy_o,
  output logic [CNT_SIZE-1:0]  pkt_count_o
);
  typedef enum logic {HEADER, PAYLOAD} state_t;
  state_t               state_q, state_d;
  logic [LEN_SIZE-1:0]  rem_q, rem_d;
  logic [DATA_SIZE-1:0] data_q, data_d;
  logic                 tx_q, tx_d, sop_q, sop_d, eop_q, eop_d;
  logic [CNT_SIZE-1:0]  cnt_q, cnt_d;
  logic                 pop, last;
  // Pop whenever the output register is free or being drained this cycle.
  assign rx_ack_o    = !flush_i && (!tx_q || tx_ack_i);
  assign pop         = rx_i && rx_ack_o;
  assign last        = rem_q == LEN_SIZE'(1);
  assign tx_o        = tx_q;
  assign data_o      = data_q;
  assign sop_o       = sop_q;
  assign eop_o       = eop_q;
  assign busy_o      = state_q == PAYLOAD;
  assign pkt_count_o = cnt_q;
  // Next state: header/payload sequencing, output register load/drain, packet count.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    data_d  = data_q;
    tx_d    = tx_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    cnt_d   = cnt_q + CNT_SIZE'(tx_q && tx_ack_i && eop_q);
    if (flush_i) begin
      tx_d    = 1'b0;
      state_d = HEADER;
      rem_d   = '0;
    end else if (pop) begin
      tx_d   = 1'b1;
      data_d = data_i;
      if (state_q == HEADER) begin
        sop_d   = 1'b1;
        rem_d   = data_i[LEN_SIZE-1:0];
        eop_d   = data_i[LEN_SIZE-1:0] == '0;
        state_d = data_i[LEN_SIZE-1:0] == '0 ? HEADER : PAYLOAD;
      end else begin
        sop_d   = 1'b0;
        eop_d   = last;
        rem_d   = rem_q - LEN_SIZE'(1);
        state_d = last ? HEADER : PAYLOAD;
      end
    end else if (tx_q && tx_ack_i) begin
      tx_d = 1'b0;
    end
  end
  // State, output register and counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= HEADER;
      rem_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_rb_packet_reader.sv
// tb_rb_packet_reader: scoreboard bench for rb_packet_reader with directed packets
module tb_rb_packet_reader;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, rx = 1'b0, tx_ack = 1'b1;
  logic [31:0] din = '0;
  logic        rx_ack, tx, sop, eop, busy;
  logic [31:0] dout;
  logic [15:0] cnt;
  logic        rx_ack_w, tx_w, sop_w, eop_w, busy_w;
  logic [31:0] dout_w;
  logic [1:0]  cnt_w;

  typedef struct packed {logic [31:0] d; logic s; logic e;} word_t;
  word_t       expq[$];
  word_t       w_exp;
  logic [31:0] src[$];
  int          checks = 0, passed = 0;
  logic        busy_seen = 1'b0, prev_stall = 1'b0;
  logic [31:0] prev_d = '0;
  logic        bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  rb_packet_reader #(.DATA_SIZE(32), .LEN_SIZE(16), .CNT_SIZE(16)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .rx_i(rx), .rx_ack_o(rx_ack),
    .data_i(din), .tx_o(tx), .tx_ack_i(tx_ack), .data_o(dout), .sop_o(sop),
    .eop_o(eop), .busy_o(busy), .pkt_count_o(cnt));

  rb_packet_reader #(.DATA_SIZE(32), .LEN_SIZE(16), .CNT_SIZE(2)) u_wrap (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .rx_i(rx), .rx_ack_o(rx_ack_w),
    .data_i(din), .tx_o(tx_w), .tx_ack_i(tx_ack), .data_o(dout_w), .sop_o(sop_w),
    .eop_o(eop_w), .busy_o(busy_w), .pkt_count_o(cnt_w));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [31:0] w, input logic s, input logic e);
    src.push_back(w);
    expq.push_back({w, s, e});
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && (src.size() > 0 || expq.size() > 0 || tx); i++) cyc();
    chk({name, "_drained"}, 32'(src.size() + expq.size()) + 32'(tx), 32'd0);
  endtask

  // Upstream ring-buffer model: pops on handshake, presents the head word.
  always @(posedge clk) begin
    if (rst_n && rx && rx_ack && src.size() > 0) void'(src.pop_front());
    #1;
    rx  = src.size() > 0;
    din = src.size() > 0 ? src[0] : 32'h0;
  end

  // Monitor: compares every accepted downstream word against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) prev_stall = 1'b0;
    else begin
      if (busy) busy_seen = 1'b1;
      if (prev_stall) chk("stall_hold_data", dout, prev_d);
      if (tx && !tx_ack) chk("stall_rx_ack", 32'(rx_ack), 32'd0);
      prev_stall = tx && !tx_ack;
      prev_d     = dout;
      if (tx && tx_ack) begin
        if (expq.size() == 0) begin
          checks++;
          $display("FAIL unexpected_word: got %h expected none", dout);
        end else begin
          w_exp = expq.pop_front();
          chk("word_data", dout, w_exp.d);
          chk("word_sop", 32'(sop), 32'(w_exp.s));
          chk("word_eop", 32'(eop), 32'(w_exp.e));
        end
      end
    end
  end

  initial begin
    send(32'h0, 1'b1, 1'b1);
    repeat (3) cyc();
    chk("rst_tx", 32'(tx), 32'd0);
    chk("rst_data", dout, 32'd0);
    chk("rst_sop", 32'(sop), 32'd0);
    chk("rst_eop", 32'(eop), 32'd0);
    chk("rst_rx_ack", 32'(rx_ack), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    rst_n = 1'b1;
    cyc();
    chk("first_tx_after_reset", 32'(tx), 32'd1);
    drain("reset_pkt");
    chk("cnt_after_reset_pkt", 32'(cnt), 32'd1);

    send(32'h0000_0003, 1'b1, 1'b0);
    send(32'hAAAA_0001, 1'b0, 1'b0);
    send(32'hBBBB_0002, 1'b0, 1'b0);
    send(32'hCCCC_0003, 1'b0, 1'b1);
    for (int i = 0; i < 20 && !tx; i++) cyc();
    for (int k = 0; k < 4; k++) begin
      chk("stream_no_bubble", 32'(tx), 32'd1);
      cyc();
    end
    drain("stream");
    chk("cnt_after_stream", 32'(cnt), 32'd2);

    busy_seen = 1'b0;
    send(32'h0, 1'b1, 1'b1);
    send(32'h0, 1'b1, 1'b1);
    drain("hdr_only");
    chk("hdr_only_busy_never", 32'(busy_seen), 32'd0);
    chk("cnt_after_hdr_only", 32'(cnt), 32'd4);

    send(32'h0000_0004, 1'b1, 1'b0);
    send(32'h1111_1111, 1'b0, 1'b0);
    send(32'h2222_2222, 1'b0, 1'b0);
    send(32'h3333_3333, 1'b0, 1'b0);
    send(32'h4444_4444, 1'b0, 1'b1);
    cyc();
    cyc();
    for (int k = 0; k < 4; k++) begin
      tx_ack = bp_pat[k];
      cyc();
    end
    tx_ack = 1'b1;
    drain("backpressure");
    chk("cnt_after_backpressure", 32'(cnt), 32'd5);

    send(32'h0000_0005, 1'b1, 1'b0);
    send(32'h5555_0001, 1'b0, 1'b0);
    send(32'h5555_0002, 1'b0, 1'b0);
    for (int i = 0; i < 50 && src.size() > 0; i++) cyc();
    flush = 1'b1;
    #1;
    chk("flush_rx_ack", 32'(rx_ack), 32'd0);
    chk("flush_busy_before", 32'(busy), 32'd1);
    cyc();
    flush = 1'b0;
    chk("flush_tx", 32'(tx), 32'd0);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_cnt_kept", 32'(cnt), 32'd5);
    send(32'h0000_0001, 1'b1, 1'b0);
    send(32'hDEAD_BEEF, 1'b0, 1'b1);
    drain("after_flush");
    chk("cnt_after_flush_pkt", 32'(cnt), 32'd6);

    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) send(32'h0, 1'b1, 1'b1);
    drain("wrap");
    chk("wrap_cnt2", 32'(cnt_w), 32'd1);
    chk("wrap_cnt16", 32'(cnt), 32'd5);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
